// File: rtl/parallel2serial_tx.sv
// ----------------------------------------------------------------------------
// parallel2serial_tx
//
// Transmitter for the start-pulse serial link.  A WIDTH-bit word is accepted
// from an upstream producer via a valid/ready handshake and sent one bit per
// clock, LSB first.  serial_start marks the cycle carrying bit 0.  At least
// IDLE_GAP zero cycles follow each word so the receiver can raise its
// end-of-conversion flag; tx_done pulses in the first of those cycles.
//
// Optional feature (macro P2S_PARITY_EN): when defined, one extra PARITY
// cycle carrying the even parity (XOR) of the word is sent after the last
// data bit, before the GAP cycles.
//
// Parameters:
//   WIDTH    : word width in bits, 2..16
//   IDLE_GAP : number of GAP cycles after the last bit, >= 1
//
// Ports:
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   din          in   parallel word, sampled only on handshake
//   din_valid    in   producer has a word on din
//   din_ready    out  high only in IDLE (combinational from state)
//   serial_start out  registered, high while d_out carries bit 0
//   d_out        out  registered serial data
//   busy         out  registered, high in every state except IDLE
//   tx_done      out  registered, one-cycle pulse after the final serial bit
// ----------------------------------------------------------------------------
module parallel2serial_tx #(
    parameter int WIDTH    = 8,
    parameter int IDLE_GAP = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             serial_start,
    output logic             d_out,
    output logic             busy,
    output logic             tx_done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam int GAP_W = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;

    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(IDLE_GAP - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
`ifdef P2S_PARITY_EN
        S_PARITY = 2'd3,
`endif
        S_GAP    = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    // r_shreg holds the bits still to be sent; bit 0 is always the next one
    logic [WIDTH-1:0]   r_shreg;
    logic [WIDTH-1:0]   w_shreg_nxt;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic [CNT_W-1:0]   w_bit_cnt_nxt;
    logic [GAP_W-1:0]   r_gap_cnt;
    logic [GAP_W-1:0]   w_gap_cnt_nxt;

    logic               r_serial_start;
    logic               r_d_out;
    logic               r_busy;
    logic               r_tx_done;
    logic               w_start_nxt;
    logic               w_dout_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;

`ifdef P2S_PARITY_EN
    logic               r_parity;
    logic               w_parity_nxt;
`endif

    assign din_ready    = (r_state == S_IDLE);
    assign serial_start = r_serial_start;
    assign d_out        = r_d_out;
    assign busy         = r_busy;
    assign tx_done      = r_tx_done;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus the values the registered outputs take next cycle.
    // Outputs are computed one cycle ahead so that they come straight from
    // flops, which the receiver samples on the same clock.
    always_comb begin
        w_state_nxt   = r_state;
        w_shreg_nxt   = r_shreg;
        w_bit_cnt_nxt = r_bit_cnt;
        w_gap_cnt_nxt = r_gap_cnt;
        w_start_nxt   = 1'b0;
        w_dout_nxt    = 1'b0;
        w_busy_nxt    = 1'b1;
        w_done_nxt    = 1'b0;
`ifdef P2S_PARITY_EN
        w_parity_nxt  = r_parity;
`endif

        case (r_state)
            S_IDLE: begin
                w_busy_nxt = 1'b0;
                if (din_valid) begin
                    // bit 0 goes straight to d_out; the rest wait in r_shreg
                    w_state_nxt   = S_SHIFT;
                    w_shreg_nxt   = {1'b0, din[WIDTH-1:1]};
                    w_bit_cnt_nxt = '0;
                    w_start_nxt   = 1'b1;
                    w_dout_nxt    = din[0];
                    w_busy_nxt    = 1'b1;
`ifdef P2S_PARITY_EN
                    w_parity_nxt  = ^din;
`endif
                end
            end

            S_SHIFT: begin
                if (r_bit_cnt == BIT_LAST) begin
`ifdef P2S_PARITY_EN
                    w_state_nxt   = S_PARITY;
                    w_dout_nxt    = r_parity;
`else
                    w_state_nxt   = S_GAP;
                    w_gap_cnt_nxt = '0;
                    w_done_nxt    = 1'b1;
`endif
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
                    w_dout_nxt    = r_shreg[0];
                    w_shreg_nxt   = {1'b0, r_shreg[WIDTH-1:1]};
                end
            end

`ifdef P2S_PARITY_EN
            S_PARITY: begin
                w_state_nxt   = S_GAP;
                w_gap_cnt_nxt = '0;
                w_done_nxt    = 1'b1;
            end
`endif

            S_GAP: begin
                if (r_gap_cnt == GAP_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_busy_nxt  = 1'b0;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt + GAP_W'(1);
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // Datapath, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shreg        <= '0;
            r_bit_cnt      <= '0;
            r_gap_cnt      <= '0;
            r_serial_start <= 1'b0;
            r_d_out        <= 1'b0;
            r_busy         <= 1'b0;
            r_tx_done      <= 1'b0;
`ifdef P2S_PARITY_EN
            r_parity       <= 1'b0;
`endif
        end else begin
            r_shreg        <= w_shreg_nxt;
            r_bit_cnt      <= w_bit_cnt_nxt;
            r_gap_cnt      <= w_gap_cnt_nxt;
            r_serial_start <= w_start_nxt;
            r_d_out        <= w_dout_nxt;
            r_busy         <= w_busy_nxt;
            r_tx_done      <= w_done_nxt;
`ifdef P2S_PARITY_EN
            r_parity       <= w_parity_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_parallel2serial_tx.sv
// ----------------------------------------------------------------------------
// Testbench for parallel2serial_tx.
// A timeline model counts the cycles remaining in the current frame and
// predicts busy / din_ready / serial_start / tx_done every cycle.  Accepted
// words are pushed into a scoreboard queue; a monitor rebuilds each word from
// the serial stream and compares it against the queue head.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_parallel2serial_tx;

    localparam int W = 8;
    localparam int G = 1;
`ifdef P2S_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int FRAME = W + P + G;   // busy cycles per word

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [W-1:0] din = '0;
    logic         din_valid = 1'b0;
    logic         din_ready;
    logic         serial_start;
    logic         d_out;
    logic         busy;
    logic         tx_done;

    parallel2serial_tx #(.WIDTH(W), .IDLE_GAP(G)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .din          (din),
        .din_valid    (din_valid),
        .din_ready    (din_ready),
        .serial_start (serial_start),
        .d_out        (d_out),
        .busy         (busy),
        .tx_done      (tx_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: cycles left in the current frame, and accepted words
    // ------------------------------------------------------------------
    int           m_rem   = 0;
    int           acc_cnt = 0;
    logic [W-1:0] sb_q[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rem = 0;
            sb_q.delete();
        end else if (m_rem > 0) begin
            m_rem = m_rem - 1;
        end else if (din_valid) begin
            sb_q.push_back(din);
            m_rem   = FRAME;
            acc_cnt = acc_cnt + 1;
        end
    end

    // ------------------------------------------------------------------
    // Monitor: sampled on the falling edge
    // ------------------------------------------------------------------
    logic         col_active = 1'b0;
    int           col_idx    = 0;
    logic [W-1:0] col_word   = '0;
    logic [W-1:0] exp_word   = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_serial_start", 32'(serial_start), 32'd0);
            chk("rst_d_out",        32'(d_out),        32'd0);
            chk("rst_busy",         32'(busy),         32'd0);
            chk("rst_tx_done",      32'(tx_done),      32'd0);
            chk("rst_din_ready",    32'(din_ready),    32'd1);
            col_active = 1'b0;
        end else begin
            chk("busy",         32'(busy),         32'(m_rem != 0));
            chk("din_ready",    32'(din_ready),    32'(m_rem == 0));
            chk("serial_start", 32'(serial_start), 32'(m_rem == FRAME));
            chk("tx_done",      32'(tx_done),      32'(m_rem == G));

            if (serial_start) begin
                if (col_active) chk("start_overlap", 32'd1, 32'd0);
                if (sb_q.size() == 0) begin
                    chk("start_without_word", 32'd1, 32'd0);
                end else begin
                    exp_word   = sb_q.pop_front();
                    col_active = 1'b1;
                    col_idx    = 0;
                    col_word   = '0;
                end
            end

            if (col_active) begin
                if (col_idx < W) col_word[col_idx] = d_out;
                else             chk("parity_bit", 32'(d_out), 32'(^exp_word));
                col_idx++;
                if (col_idx == W) chk("word", 32'(col_word), 32'(exp_word));
                if (col_idx == W + P) col_active = 1'b0;
            end else begin
                chk("d_out_idle", 32'(d_out), 32'd0);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic wait_accept();
        int start_cnt;
        start_cnt = acc_cnt;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk);
            #1;
            if (acc_cnt != start_cnt) return;
        end
        chk("accept_timeout", 32'd1, 32'd0);
    endtask

    task automatic send(input logic [W-1:0] word, input bit keep_valid);
        @(negedge clk);
        din       = word;
        din_valid = 1'b1;
        wait_accept();
        if (!keep_valid) begin
            @(negedge clk);
            din_valid = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        din_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // power-on reset
        #3 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        idle(2);

        // single word, then back-to-back with valid held
        send(8'hA5, 1'b0);
        idle(FRAME + 3);
        send(8'h3C, 1'b1);
        send(8'hC3, 1'b0);
        idle(FRAME + 3);

        // din toggles to FF with valid high while an all-zero word shifts out
        send(8'h00, 1'b1);
        for (int k = 0; k < W; k++) begin
            din       = 8'hFF;
            din_valid = 1'b1;
            @(negedge clk);
        end
        din_valid = 1'b0;
        idle(FRAME + 3);

        // parity-heavy words
        send(8'h07, 1'b0);
        send(8'h01, 1'b0);
        send(8'h80, 1'b0);
        send(8'h5A, 1'b0);
        idle(FRAME + 3);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            din       = W'($urandom);
            din_valid = ($urandom_range(0, 3) != 0);
        end

        // reset in the middle of a frame
        send(W'($urandom), 1'b0);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        din_valid = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        idle(FRAME + 3);

        // more randomized traffic after the reset
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            din       = W'($urandom);
            din_valid = ($urandom_range(0, 2) != 0);
        end

        // drain
        idle(FRAME + 4);
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        chk("collector_idle",   32'(col_active),  32'd0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
